if_stage: RTL and testbench

Instruction fetch stage for the single-issue RV64I core. It holds the PC and issues one instruction-memory request at a time. It returns each fetched 32-bit instruction and its address to the decode stage through a valid/ready handshake. Redirects from the execute stage (taken branches, jal/jalr) retarget fetch and drop any wrong-path data still in flight.

---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV64I instruction fetch stage: PC, single-outstanding imem request, decode handshake
// Redirects retarget the PC in any state; a response already in flight when one arrives is dropped.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_addr,
    input  logic        id_ready,
    output logic [63:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] inst_addr_q, inst_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~64'h3;

    // Request side depends only on registered state, never on inputs.
    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_addr  = inst_addr_q;
    assign fetch_cnt  = fetch_cnt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (inst_valid_q && id_ready) begin
            fetch_cnt_d = fetch_cnt_q + 64'd1;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_gnt) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 64'd4;
                    drop_d     = redirect_valid;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // A redirect in the response cycle kills the data just like a pending drop.
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_addr_d  = req_addr_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (id_ready || redirect_valid) begin
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            req_addr_q   <= 64'd0;
            inst_q       <= 32'd0;
            inst_addr_q  <= 64'd0;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a latency-configurable instruction memory
// The memory model grants/responds at negedge; a posedge monitor predicts delivered instructions.
module tb_if_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        id_ready;
    logic [63:0] fetch_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        pend;
    exp_t        popped;
    bit          live;
    bit          nop_mode;
    int          gnt_delay;
    int          rsp_lat;
    int          rsp_cnt;
    int          wait_cnt;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_addr      (inst_addr),
        .id_ready       (id_ready),
        .fetch_cnt      (fetch_cnt)
    );

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return nop_mode ? 32'h0000_0013 : (a[31:0] ^ 32'h1357_9BDF);
    endfunction

    // Instruction memory: grant after gnt_delay stall cycles, answer rsp_lat cycles after grant.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        rsp_cnt     = 0;
        wait_cnt    = 0;
        rsp_data    = 32'd0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rsp_data;
                end
            end
            if (imem_req && rst) begin
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    imem_gnt = 1'b1;
                    rsp_cnt  = rsp_lat;
                    rsp_data = mem_data(imem_addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Transaction model: a grant is live unless a redirect coincides with it or with its wait.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            live = 1'b0;
        end else begin
            if (inst_valid) begin
                if (id_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_handshake got addr=%h inst=%h exp=<no instruction expected>", inst_addr, inst);
                    end else begin
                        popped = exp_q.pop_front();
                        if (inst !== popped.data || inst_addr !== popped.addr)
                            $display("FAIL sb_handshake got addr=%h inst=%h exp addr=%h inst=%h", inst_addr, inst, popped.addr, popped.data);
                        else
                            n_pass++;
                    end
                end else if (redirect_valid && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
            end
            if (live && imem_rvalid) begin
                if (!redirect_valid) exp_q.push_back(pend);
                live = 1'b0;
            end else if (live && redirect_valid) begin
                live = 1'b0;
            end
            if (imem_req && imem_gnt) begin
                pend.addr = imem_addr;
                pend.data = mem_data(imem_addr);
                live      = !redirect_valid;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sig(input bit want_valid, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (want_valid ? inst_valid : imem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'd0) $display("FAIL reset_inst got=%h exp=0", inst); else n_pass++;
        n_checks++; if (inst_addr !== 64'd0) $display("FAIL reset_inst_addr got=%h exp=0", inst_addr); else n_pass++;
        n_checks++; if (fetch_cnt !== 64'd0) $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [63:0] ea;
        nop_mode = 1'b1;
        id_ready = 1'b1;
        rst      = 1'b1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL first_req_early got=%b exp=0", imem_req); else n_pass++;
        step();
        for (int c = 0; c < 9; c++) begin
            ea = RESET_PC + 64'(4 * (c / 3));
            n_checks++; if (imem_req !== (c % 3 == 0)) $display("FAIL zw_req c=%0d got=%b exp=%b", c, imem_req, (c % 3 == 0)); else n_pass++;
            if (c % 3 == 0) begin
                n_checks++; if (imem_addr !== ea) $display("FAIL zw_addr c=%0d got=%h exp=%h", c, imem_addr, ea); else n_pass++;
            end
            n_checks++; if (inst_valid !== (c % 3 == 2)) $display("FAIL zw_valid c=%0d got=%b exp=%b", c, inst_valid, (c % 3 == 2)); else n_pass++;
            if (c % 3 == 2) begin
                n_checks++; if (inst !== 32'h13 || inst_addr !== ea) $display("FAIL zw_inst c=%0d got=%h@%h exp=00000013@%h", c, inst, inst_addr, ea); else n_pass++;
            end
            step();
        end
        n_checks++; if (fetch_cnt !== 64'd3) $display("FAIL zw_cnt got=%0d exp=3", fetch_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        id_ready = 1'b0;
        wait_sig(1'b1, 10, ok);
        n_checks++; if (!ok) $display("FAIL bp_wait got=timeout exp=inst_valid"); else n_pass++;
        nop_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_addr !== RESET_PC + 64'd12 || imem_req !== 1'b0 || fetch_cnt !== 64'd3)
                $display("FAIL bp_hold i=%0d got v=%b inst=%h addr=%h req=%b cnt=%0d exp v=1 inst=00000013 addr=%h req=0 cnt=3",
                         i, inst_valid, inst, inst_addr, imem_req, fetch_cnt, RESET_PC + 64'd12);
            else n_pass++;
            step();
        end
        id_ready = 1'b1;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 64'd16) $display("FAIL bp_next got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RESET_PC + 64'd16); else n_pass++;
        n_checks++; if (fetch_cnt !== 64'd4) $display("FAIL bp_cnt got=%0d exp=4", fetch_cnt); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit ok;
        rsp_lat = 3;
        step();
        wait_sig(1'b0, 10, ok);
        n_checks++; if (!ok) $display("FAIL rw_wait_req got=timeout exp=imem_req"); else n_pass++;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1002;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 64'h8000_1000) $display("FAIL rw_addr got req=%b addr=%h exp req=0 addr=0000000080001000", imem_req, imem_addr); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (inst_valid !== 1'b0) $display("FAIL rw_dropped i=%0d got=%b exp=0", i, inst_valid); else n_pass++;
            step();
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8000_1000) $display("FAIL rw_refetch got req=%b addr=%h exp req=1 addr=0000000080001000", imem_req, imem_addr); else n_pass++;
        wait_sig(1'b1, 10, ok);
        n_checks++; if (!ok || inst_addr !== 64'h8000_1000) $display("FAIL rw_inst got ok=%b addr=%h exp ok=1 addr=0000000080001000", ok, inst_addr); else n_pass++;
    endtask

    task automatic test_redirect_gnt();
        bit ok;
        logic [63:0] tgt;
        tgt     = 64'hFFFF_FFFF_FFFF_FFFC;
        rsp_lat = 1;
        step();
        wait_sig(1'b0, 10, ok);
        n_checks++; if (!ok) $display("FAIL rg_wait_req got=timeout exp=imem_req"); else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== tgt || inst_valid !== 1'b0) $display("FAIL rg_wait got req=%b addr=%h v=%b exp req=0 addr=%h v=0", imem_req, imem_addr, inst_valid, tgt); else n_pass++;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== tgt || inst_valid !== 1'b0) $display("FAIL rg_refetch got req=%b addr=%h v=%b exp req=1 addr=%h v=0", imem_req, imem_addr, inst_valid, tgt); else n_pass++;
        step();
        n_checks++; if (inst_valid !== 1'b0 || imem_addr !== 64'd0) $display("FAIL rg_wrap got v=%b addr=%h exp v=0 addr=0", inst_valid, imem_addr); else n_pass++;
        step();
        n_checks++; if (inst_valid !== 1'b1 || inst_addr !== tgt || inst !== (tgt[31:0] ^ 32'h1357_9BDF)) $display("FAIL rg_inst got v=%b %h@%h exp v=1 %h@%h", inst_valid, inst, inst_addr, tgt[31:0] ^ 32'h1357_9BDF, tgt); else n_pass++;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0) $display("FAIL rg_next got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        logic [63:0] cnt0;
        id_ready = 1'b0;
        wait_sig(1'b1, 10, ok);
        n_checks++; if (!ok) $display("FAIL rh_wait got=timeout exp=inst_valid"); else n_pass++;
        cnt0           = fetch_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_2000;
        id_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (fetch_cnt !== cnt0 + 64'd1) $display("FAIL rh_cnt got=%0d exp=%0d", fetch_cnt, cnt0 + 64'd1); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_2000) $display("FAIL rh_next got v=%b req=%b addr=%h exp v=0 req=1 addr=0000000080002000", inst_valid, imem_req, imem_addr); else n_pass++;
        wait_sig(1'b1, 10, ok);
        n_checks++; if (!ok || inst_addr !== 64'h8000_2000) $display("FAIL rh_inst got ok=%b addr=%h exp ok=1 addr=0000000080002000", ok, inst_addr); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        rsp_lat = 3;
        step();
        wait_sig(1'b0, 10, ok);
        n_checks++; if (!ok) $display("FAIL rs_wait_req got=timeout exp=imem_req"); else n_pass++;
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 || fetch_cnt !== 64'd0 || inst !== 32'd0)
            $display("FAIL rs_async got req=%b addr=%h v=%b cnt=%0d inst=%h exp req=0 addr=%h v=0 cnt=0 inst=0", imem_req, imem_addr, inst_valid, fetch_cnt, inst, RESET_PC);
        else n_pass++;
        step();
        gnt_delay = 2;
        rst       = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) $display("FAIL rs_restart i=%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0", i, imem_req, imem_addr, inst_valid, RESET_PC); else n_pass++;
            step();
        end
        gnt_delay = 0;
        wait_sig(1'b1, 10, ok);
        n_checks++; if (!ok || inst_addr !== RESET_PC) $display("FAIL rs_inst got ok=%b addr=%h exp ok=1 addr=%h", ok, inst_addr, RESET_PC); else n_pass++;
        step();
    endtask

    task automatic test_end();
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_checks++; if (fetch_cnt !== 64'd1) $display("FAIL end_cnt got=%0d exp=1", fetch_cnt); else n_pass++;
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        id_ready       = 1'b0;
        nop_mode       = 1'b0;
        gnt_delay      = 0;
        rsp_lat        = 1;
        live           = 1'b0;
        pend           = '0;
        popped         = '0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_hold();
        test_reset_in_wait();
        test_end();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
